// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller and its priority encoder.
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic CFG_CTRL = 1'b0;
  localparam logic CFG_PEND = 1'b1;
  localparam int   CODE_W   = 3;

endpackage

// File: rtl/interrupt_controller_prio_encoder.sv
// Fixed-priority encoder: lowest set index wins, line i reports code i+1, 0 means none.
module prio_encoder
  import int_ctrl_pkg::*;
#(
  parameter int N_IRQ = 7
) (
  input  logic [N_IRQ-1:0]  eligible,
  output logic              valid,
  output logic [CODE_W-1:0] code
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    valid = 1'b0;
    code  = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        valid = 1'b1;
        code  = CODE_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-latching, maskable interrupt controller presenting one prioritized code to the
// datapath through an ack/reti handshake with the control unit.
module interrupt_controller
  import int_ctrl_pkg::*;
#(
  parameter int N_IRQ       = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IRQ-1:0]  irq,
  input  logic              boundary,
  input  logic              int_ack,
  input  logic              reti,
  input  logic              cfg_we,
  input  logic              cfg_addr,
  input  logic [7:0]        cfg_wdata,
  output logic [7:0]        cfg_rdata,
  output logic [CODE_W-1:0] interrupciones,
  output logic [CODE_W-1:0] in_service,
  output logic              busy
);

  state_t                              state;
  logic                                ie;
  logic [N_IRQ-1:0]                    mask;
  logic [N_IRQ-1:0]                    pending;
  logic [SYNC_STAGES-1:0][N_IRQ-1:0]   sync_q;
  logic [N_IRQ-1:0]                    prev_q;
  logic [N_IRQ-1:0]                    edge_det;
  logic [N_IRQ-1:0]                    eligible;
  logic [N_IRQ-1:0]                    ack_clr;
  logic [N_IRQ-1:0]                    w1c_clr;
  logic                                enc_valid;
  logic [CODE_W-1:0]                   enc_code;
  logic                                ctrl_wr;
  logic                                ack_fire;

  assign ctrl_wr  = cfg_we && (cfg_addr == CFG_CTRL);
  assign ack_fire = (state == REQ) && int_ack;
  assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign eligible = pending & mask;
  assign w1c_clr  = (cfg_we && (cfg_addr == CFG_PEND)) ? cfg_wdata[N_IRQ-1:0] : '0;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (ack_fire && (interrupciones == CODE_W'(i + 1))) ack_clr[i] = 1'b1;
    end
  end

  prio_encoder #(.N_IRQ(N_IRQ)) u_prio (
    .eligible (eligible),
    .valid    (enc_valid),
    .code     (enc_code)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Set dominates clear so an edge arriving with an ack or W1C is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~(ack_clr | w1c_clr)) | edge_det;
      if (ctrl_wr) mask <= cfg_wdata[N_IRQ-1:0];
    end
  end

  // ie is owned here because the handshake overrides software writes in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      ie             <= 1'b0;
      interrupciones <= '0;
      in_service     <= '0;
      busy           <= 1'b0;
    end else begin
      if (ctrl_wr) ie <= cfg_wdata[7];
      case (state)
        IDLE: begin
          if (ie && enc_valid && boundary) begin
            state          <= REQ;
            interrupciones <= enc_code;
            busy           <= 1'b1;
          end
        end
        REQ: begin
          if (int_ack) begin
            state          <= SERVICE;
            ie             <= 1'b0;
            in_service     <= interrupciones;
            interrupciones <= '0;
          end
        end
        SERVICE: begin
          if (reti) begin
            state      <= IDLE;
            ie         <= 1'b1;
            in_service <= '0;
            busy       <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          interrupciones <= '0;
          in_service     <= '0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    if (cfg_addr == CFG_CTRL) begin
      cfg_rdata[7]         = ie;
      cfg_rdata[N_IRQ-1:0] = mask;
    end else begin
      cfg_rdata[N_IRQ-1:0] = pending;
    end
  end

endmodule
